// File: rtl/weight_replay_buffer.sv
// weight_replay_buffer: ping-pong coefficient store that loads a kernel from one FIFO
// and replays it REPLAY times to another while the next kernel loads.
module weight_replay_buffer #(
    parameter int COEFF_WIDTH = 16,
    parameter int KERN_SIZE   = 9,
    parameter int REPLAY      = 4
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst,
    input  logic [COEFF_WIDTH-1:0] input_V_dout,
    input  logic                   input_V_empty_n,
    output logic                   input_V_read,
    output logic [COEFF_WIDTH-1:0] output_V_din,
    input  logic                   output_V_full_n,
    output logic                   output_V_write,
    output logic                   kernel_done
);
    localparam int AW = KERN_SIZE > 1 ? $clog2(KERN_SIZE) : 1;
    localparam int RW = REPLAY > 1 ? $clog2(REPLAY) : 1;
    localparam logic [AW-1:0] A_LAST = AW'(KERN_SIZE - 1);
    localparam logic [RW-1:0] R_LAST = RW'(REPLAY - 1);

    logic [COEFF_WIDTH-1:0] mem_q [2][KERN_SIZE];
    logic [1:0]    full_q, full_d;
    logic          wb_q, wb_d, rb_q, rb_d;
    logic [AW-1:0] wa_q, wa_d, ra_q, ra_d;
    logic [RW-1:0] rc_q, rc_d;
    logic          wa_last, ra_last, rc_last, load_done;

    always_comb begin
        input_V_read   = input_V_empty_n & ~full_q[wb_q] & ~ap_rst;
        output_V_write = full_q[rb_q] & output_V_full_n & ~ap_rst;
        output_V_din   = output_V_write ? mem_q[rb_q][ra_q] : '0;
        wa_last        = wa_q == A_LAST;
        ra_last        = ra_q == A_LAST;
        rc_last        = rc_q == R_LAST;
        load_done      = input_V_read & wa_last;
        kernel_done    = output_V_write & ra_last & rc_last;
        wa_d           = input_V_read ? (wa_last ? '0 : wa_q + 1'b1) : wa_q;
        wb_d           = wb_q ^ load_done;
        ra_d           = output_V_write ? (ra_last ? '0 : ra_q + 1'b1) : ra_q;
        rc_d           = (output_V_write & ra_last) ? (rc_last ? '0 : rc_q + 1'b1) : rc_q;
        rb_d           = rb_q ^ kernel_done;
        // load and release always target different banks, so both updates can land together
        full_d         = full_q;
        if (load_done) full_d[wb_q] = 1'b1;
        if (kernel_done) full_d[rb_q] = 1'b0;
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            full_q <= '0;
            wb_q   <= 1'b0;
            rb_q   <= 1'b0;
            wa_q   <= '0;
            ra_q   <= '0;
            rc_q   <= '0;
        end else begin
            full_q <= full_d;
            wb_q   <= wb_d;
            rb_q   <= rb_d;
            wa_q   <= wa_d;
            ra_q   <= ra_d;
            rc_q   <= rc_d;
        end
    end

    // coefficient storage is deliberately left out of reset
    always_ff @(posedge ap_clk) begin
        if (input_V_read) mem_q[wb_q][wa_q] <= input_V_dout;
    end
endmodule

// File: tb/tb_weight_replay_buffer.sv
// tb_weight_replay_buffer: directed and random scenarios checked against a kernel-queue model.
module tb_weight_replay_buffer;
    localparam int K = 9;
    localparam int R = 4;

    logic        ap_clk = 1'b0;
    logic        ap_rst = 1'b1;
    logic [15:0] input_V_dout = '0;
    logic        input_V_empty_n = 1'b0;
    logic        output_V_full_n = 1'b1;
    logic        input_V_read, output_V_write, kernel_done;
    logic [15:0] output_V_din;

    weight_replay_buffer #(.COEFF_WIDTH(16), .KERN_SIZE(K), .REPLAY(R)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .input_V_dout(input_V_dout), .input_V_empty_n(input_V_empty_n), .input_V_read(input_V_read),
        .output_V_din(output_V_din), .output_V_full_n(output_V_full_n), .output_V_write(output_V_write),
        .kernel_done(kernel_done)
    );

    always #5 ap_clk = ~ap_clk;

    int checks = 0;
    int errors = 0;
    logic [15:0] feed[$];
    logic [15:0] part[$];
    logic [15:0] kq[$];
    int pos = 0;
    logic o_rd, o_wr, o_done;
    logic [15:0] o_din;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // one clock cycle: drive, compare against the model at negedge, advance the model
    task automatic cyc(input bit r, input bit gate, input bit fn);
        int nk;
        logic e_rd, e_wr, e_done;
        logic [15:0] e_din;
        ap_rst = r;
        input_V_empty_n = gate && feed.size() > 0;
        input_V_dout = input_V_empty_n ? feed[0] : 16'($urandom);
        output_V_full_n = fn;
        @(negedge ap_clk);
        nk = kq.size() / K;
        e_rd = !r && input_V_empty_n && nk < 2;
        e_wr = !r && nk >= 1 && fn;
        e_din = e_wr ? kq[pos % K] : 16'h0;
        e_done = e_wr && pos == K * R - 1;
        o_rd = input_V_read;
        o_wr = output_V_write;
        o_din = output_V_din;
        o_done = kernel_done;
        chk("read", 32'(o_rd), 32'(e_rd));
        chk("write", 32'(o_wr), 32'(e_wr));
        chk("din", 32'(o_din), 32'(e_din));
        chk("kernel_done", 32'(o_done), 32'(e_done));
        if (r) begin
            kq.delete();
            part.delete();
            pos = 0;
        end else begin
            if (e_wr) begin
                if (e_done) begin
                    repeat (K) void'(kq.pop_front());
                    pos = 0;
                end else pos++;
            end
            if (e_rd) begin
                part.push_back(feed.pop_front());
                if (part.size() == K) begin
                    kq = {kq, part};
                    part.delete();
                end
            end
        end
        @(posedge ap_clk);
        #1;
    endtask

    task automatic do_reset();
        feed.delete();
        repeat (2) cyc(1'b1, 1'b1, 1'b1);
    endtask

    initial begin
        int fw, dt, dn, nw, nr, td, t101;
        bit seen;
        #1;
        // single kernel, no backpressure
        do_reset();
        for (int i = 1; i <= 9; i++) feed.push_back(16'(i));
        fw = -1; dt = -1; dn = 0; nw = 0;
        for (int t = 0; t < 60; t++) begin
            cyc(1'b0, 1'b1, 1'b1);
            if (o_wr) nw++;
            if (o_wr && fw < 0) fw = t;
            if (o_done) begin dn++; dt = t; end
        end
        chk("first_write_cycle", 32'(fw), 32'd9);
        chk("done_cycle", 32'(dt), 32'd44);
        chk("done_count", 32'(dn), 32'd1);
        chk("write_count", 32'(nw), 32'd36);
        // backpressure every third cycle
        do_reset();
        for (int i = 1; i <= 9; i++) feed.push_back(16'(i));
        dn = 0; nw = 0;
        for (int t = 0; t < 70; t++) begin
            cyc(1'b0, 1'b1, (t % 3) != 2);
            if (o_wr) nw++;
            if (o_done) begin
                dn++;
                chk("done_on_36th", 32'(nw), 32'd36);
            end
        end
        chk("bp_done_count", 32'(dn), 32'd1);
        chk("bp_write_count", 32'(nw), 32'd36);
        // ping-pong back-to-back kernels
        do_reset();
        for (int i = 1; i <= 9; i++) feed.push_back(16'(i));
        for (int i = 101; i <= 109; i++) feed.push_back(16'(i));
        t101 = -1;
        for (int t = 0; t < 90; t++) begin
            cyc(1'b0, 1'b1, 1'b1);
            if (o_wr && o_din == 16'd101 && t101 < 0) t101 = t;
        end
        chk("pingpong_101_cycle", 32'(t101), 32'd45);
        // three kernels queued with the output blocked
        do_reset();
        for (int i = 0; i < 27; i++) feed.push_back(16'(300 + i));
        nr = 0;
        for (int t = 0; t < 30; t++) begin
            cyc(1'b0, 1'b1, 1'b0);
            if (o_rd) nr++;
        end
        chk("both_full_reads", 32'(nr), 32'd18);
        chk("both_full_read_low", 32'(o_rd), 32'd0);
        td = -1; seen = 0;
        for (int t = 0; t < 80; t++) begin
            cyc(1'b0, 1'b1, 1'b1);
            if (td >= 0 && t == td + 1) begin
                chk("resume_after_release", 32'(o_rd), 32'd1);
                seen = 1;
            end
            if (o_done && td < 0) td = t;
        end
        chk("release_seen", 32'(seen), 32'd1);
        // reset in the middle of replay
        do_reset();
        for (int i = 1; i <= 9; i++) feed.push_back(16'(i));
        for (int t = 0; t < 19; t++) cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1);
        chk("rst_write_low", 32'(o_wr), 32'd0);
        for (int i = 50; i <= 58; i++) feed.push_back(16'(i));
        dn = 0; nw = 0;
        for (int t = 0; t < 60; t++) begin
            cyc(1'b0, 1'b1, 1'b1);
            if (o_wr) nw++;
            if (o_done) dn++;
            if (t == 9) chk("post_rst_first_word", 32'(o_din), 32'd50);
        end
        chk("post_rst_writes", 32'(nw), 32'd36);
        chk("post_rst_done", 32'(dn), 32'd1);
        // bank 1 load completes in the same cycle bank 0 is released
        do_reset();
        for (int i = 1; i <= 9; i++) feed.push_back(16'(i));
        for (int i = 201; i <= 209; i++) feed.push_back(16'(i));
        for (int i = 0; i < 3; i++) feed.push_back(16'(400 + i));
        for (int t = 0; t < 50; t++) begin
            cyc(1'b0, (t < 9) || (t >= 36), 1'b1);
            if (t == 44) begin
                chk("sim_done", 32'(o_done), 32'd1);
                chk("sim_load_last", 32'(o_rd), 32'd1);
            end
            if (t == 45) begin
                chk("sim_next_word", 32'(o_din), 32'd201);
                chk("sim_read_resume", 32'(o_rd), 32'd1);
            end
        end
        // random traffic
        do_reset();
        for (int i = 0; i < 9 * 25; i++) feed.push_back(16'($urandom));
        for (int t = 0; t < 900; t++) cyc(1'b0, $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/weight_replay_buffer.md
WEIGHT_REPLAY_BUFFER -- requirements
Module: weight_replay_buffer

Interface
REQ-001 SHALL have parameter COEFF_WIDTH, default 16: coefficient word width; equals `coeff_width.
REQ-002 SHALL have parameter KERN_SIZE, default 9: coefficients per kernel; the legal range is 2..1024.
REQ-003 SHALL have parameter REPLAY, default 4: number of times each kernel is replayed; the legal range is 1..4096.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL have port ap_clk, input, 1 bit: clock, rising edge.
REQ-006 SHALL have port ap_rst, input, 1 bit: synchronous active-high reset.
REQ-007 SHALL have port input_V_dout, input, COEFF_WIDTH bits: coefficient from the upstream weight FIFO.
REQ-008 SHALL have port input_V_empty_n, input, 1 bit: high when the upstream FIFO holds data.
REQ-009 SHALL have port input_V_read, output, 1 bit: pops one upstream word in the cycle it is high.
REQ-010 SHALL have port output_V_din, output, COEFF_WIDTH bits: replayed coefficient to the convolution engine.
REQ-011 SHALL have port output_V_full_n, input, 1 bit: high when the downstream FIFO can accept a word.
REQ-012 SHALL have port output_V_write, output, 1 bit: pushes output_V_din in the cycle it is high.
REQ-013 SHALL have port kernel_done, output, 1 bit: one-cycle pulse on the last write of the last replay of a kernel.

Function
REQ-014 SHALL store coefficients in two banks (bank 0 and bank 1), each KERN_SIZE x COEFF_WIDTH, with a per-bank full flag.
- Storage is register array or inferred RAM with asynchronous read.
REQ-015 Load side SHALL hold a write-bank pointer wb and a word counter wa in 0..KERN_SIZE-1.
REQ-016 input_V_read SHALL equal input_V_empty_n AND NOT full[wb] AND NOT ap_rst.
REQ-017 On each read, the block SHALL store input_V_dout at bank[wb][wa] and increment wa.
- When wa = KERN_SIZE-1: wa wraps to 0, full[wb] sets, wb toggles.
REQ-018 Replay side SHALL hold a read-bank pointer rb, an address counter ra in 0..KERN_SIZE-1 and a replay counter rc in 0..REPLAY-1.
REQ-019 output_V_write SHALL equal full[rb] AND output_V_full_n AND NOT ap_rst.
REQ-020 output_V_din SHALL equal bank[rb][ra] when output_V_write is high, else 0.
REQ-021 On each write, ra SHALL increment; at KERN_SIZE-1, ra wraps to 0 and rc increments.
- At ra = KERN_SIZE-1 and rc = REPLAY-1: rc wraps to 0, full[rb] clears, rb toggles, kernel_done pulses in that same cycle.
REQ-022 SHALL have a latency of 1 cycle from the cycle the last kernel word is read to the cycle of the first output write (full_n high).
- There SHALL be no bubble between the last write of one kernel and the first write of the next when the next bank is already full.
REQ-023 Simultaneous release of bank X and load completion into bank Y SHALL update both flags in the same edge without loss.
REQ-024 A load into a bank being released in the same cycle is impossible by construction and SHALL NOT occur (wb = rb implies full[wb] blocks reads).
REQ-025 When output_V_full_n is low, ra, rc, rb SHALL hold; loading SHALL continue independently.
REQ-026 With both banks full, input_V_read SHALL stay low until a bank is released; it SHALL be high the cycle after release if empty_n is high.
REQ-027 REPLAY = 1 SHALL stream each kernel once, with identical rules.

Reset
REQ-028 On ap_rst high at a rising edge, the block SHALL set wb, wa, rb, ra, rc to 0, clear both full flags and clear kernel_done.
- Bank contents are not cleared.
REQ-029 While ap_rst is high, input_V_read, output_V_write and kernel_done SHALL be 0 and output_V_din SHALL be 0.
REQ-030 Reset mid-load or mid-replay SHALL abandon partial state; the first word after reset loads into bank 0, address 0.

Verification
REQ-031 SHALL verify single kernel (KERN_SIZE=9, REPLAY=4): upstream 1..9 read cycles 0..8, full_n=1 -> 36 writes 1..9 x4 from cycle 9, kernel_done at cycle 44, then idle.
REQ-032 SHALL verify backpressure: full_n low every third cycle -> no write when low, sequence still 1..9 x4, kernel_done only on the 36th write.
REQ-033 SHALL verify ping-pong: kernels A=1..9, B=101..109 back-to-back -> B loads during A replay; the write of 101 occurs the cycle after the last write of 9, with no gap.
REQ-034 SHALL verify both banks full: three kernels queued, full_n=0 -> exactly 18 reads then input_V_read=0; the third kernel resumes loading the cycle after the first kernel_done.
REQ-035 SHALL verify reset mid-replay: ap_rst high for 1 cycle after 10 writes -> write/read 0 during reset, flags cleared; a new kernel 50..58 replays as 50..58 x4.
REQ-036 SHALL verify a simultaneous event: bank 1 load completes in the same cycle bank 0 is released -> rb=1 next cycle, write continues with bank 1 word 0, wb=0 reads resume.
